uart_cmd_parser: RTL and testbench

- Consumes received bytes from the UART driver's RX FIFO (rx_empty/r_data/rd_uart side) and turns typed ASCII hex into a byte value for the display/control logic.
- Optionally echoes every character back through the UART TX FIFO (tx_full/w_data/wr_uart side). After CR it also sends LF.
- Sits directly downstream of the UART driver's receive path, replacing push-button popping in terminal builds.

---
 rtl/uart_cmd_parser.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: converts ASCII hex typed on a UART terminal into a committed byte value.
// Build option UART_CMD_ECHO_EN: echo each received character (plus LF after CR) into the TX FIFO.
module uart_cmd_parser #(
  parameter logic [7:0] CR_CODE = 8'h0D,
  parameter logic [7:0] LF_CODE = 8'h0A,
  parameter logic [7:0] BS_CODE = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [7:0] hex_value,
  output logic       hex_valid,
  output logic       err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] POP     = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] ECHO    = 3'd3;
  localparam logic [2:0] ECHO_LF = 3'd4;

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [7:0] char_r;
  logic [7:0] acc_r;
  logic [1:0] digit_cnt_r;
  logic [7:0] hex_value_r;
  logic       hex_valid_r;
  logic       err_r;
  logic [7:0] w_data_r;
  logic [4:0] nibble_s;

  // Returns {is_hex, nibble} for an ASCII character.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] res;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      res = {1'b1, c[3:0]};
    end else if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
      res = {1'b1, c[3:0] + 4'd9};
    end else begin
      res = 5'b0_0000;
    end
    return res;
  endfunction

  // Character classification of the captured byte
  always_comb begin
    nibble_s = hex_nibble(char_r);
  end

  // Next-state logic; the echo states are only reachable in echo builds
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_empty) begin
          state_nxt_s = POP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      POP: begin
        state_nxt_s = DECODE;
      end
      DECODE: begin
`ifdef UART_CMD_ECHO_EN
        state_nxt_s = ECHO;
`else
        state_nxt_s = IDLE;
`endif
      end
      ECHO: begin
        if (!tx_full) begin
          if (char_r == CR_CODE) begin
            state_nxt_s = ECHO_LF;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = ECHO;
        end
      end
      ECHO_LF: begin
        if (!tx_full) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ECHO_LF;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register, byte capture, digit accumulation and commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      char_r      <= 8'h00;
      acc_r       <= 8'h00;
      digit_cnt_r <= 2'd0;
      hex_value_r <= 8'h00;
      hex_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hex_valid_r <= 1'b0;
      if (state_r == POP) begin
        char_r <= r_data;
      end
      if (state_r == DECODE) begin
        if (nibble_s[4]) begin
          // Shifting keeps only the two most recent digits
          acc_r <= {acc_r[3:0], nibble_s[3:0]};
          if (digit_cnt_r != 2'd2) begin
            digit_cnt_r <= digit_cnt_r + 2'd1;
          end
        end else if (char_r == CR_CODE) begin
          if (digit_cnt_r != 2'd0) begin
            hex_value_r <= acc_r;
            hex_valid_r <= 1'b1;
            err_r       <= 1'b0;
            acc_r       <= 8'h00;
            digit_cnt_r <= 2'd0;
          end
        end else if (char_r == BS_CODE) begin
          acc_r       <= 8'h00;
          digit_cnt_r <= 2'd0;
        end else begin
          err_r       <= 1'b1;
          acc_r       <= 8'h00;
          digit_cnt_r <= 2'd0;
        end
      end
    end
  end

  // Echo byte register; without echo states it is never loaded and stays 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_data_r <= 8'h00;
    end else if ((state_r == DECODE) && (state_nxt_s == ECHO)) begin
      w_data_r <= char_r;
    end else if ((state_r == ECHO) && (state_nxt_s == ECHO_LF)) begin
      w_data_r <= LF_CODE;
    end else begin
      w_data_r <= w_data_r;
    end
  end

  assign rd_uart   = (state_r == POP);
  assign w_data    = w_data_r;
  assign hex_value = hex_value_r;
  assign hex_valid = hex_valid_r;
  assign err       = err_r;

`ifdef UART_CMD_ECHO_EN
  // The push strobe follows tx_full combinationally so a stalled echo fires the cycle space opens
  assign wr_uart = ((state_r == ECHO) || (state_r == ECHO_LF)) && !tx_full;
`else
  assign wr_uart = 1'b0;
`endif

  uart_cmd_parser_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .rd_uart   (rd_uart),
    .wr_uart   (wr_uart),
    .tx_full   (tx_full),
    .hex_valid (hex_valid)
  );

endmodule

// Protocol properties of the parser's FIFO strobes and commit pulse.
module uart_cmd_parser_chk (
  input logic clk,
  input logic reset,
  input logic rd_uart,
  input logic wr_uart,
  input logic tx_full,
  input logic hex_valid
);

  a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (reset) !(rd_uart && wr_uart));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(wr_uart && tx_full));
  a_single_pulse: assert property (@(posedge clk) disable iff (reset) hex_valid |=> !hex_valid);
  a_single_pop: assert property (@(posedge clk) disable iff (reset) rd_uart |=> !rd_uart);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with RX FIFO model and echo/commit scoreboards.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
`ifdef UART_CMD_ECHO_EN
  localparam int ECHO_ON = 1;
`else
  localparam int ECHO_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       rd_uart;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] hex_value;
  logic       hex_valid;
  logic       err;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int hv_cnt = 0;
  logic       pop_pend = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] echo_q[$];
  logic [7:0] hex_q[$];

  uart_cmd_parser dut (
    .clk       (clk),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .r_data    (r_data),
    .rd_uart   (rd_uart),
    .tx_full   (tx_full),
    .w_data    (w_data),
    .wr_uart   (wr_uart),
    .hex_value (hex_value),
    .hex_valid (hex_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue a received byte and the echo it should produce
  task automatic send(input logic [7:0] c);
    rx_q.push_back(c);
    if (ECHO_ON != 0) begin
      echo_q.push_back(c);
      if (c == CR) echo_q.push_back(LF);
    end
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (((rx_q.size() != 0) || pop_pend) && (n < 400)) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drain"}, (n < 400), 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_echo_left"}, echo_q.size(), 0);
    check({tag, "_hex_left"}, hex_q.size(), 0);
  endtask

  // RX FIFO model: first-word-fall-through, pop lands after the capturing edge
  always @(negedge clk) begin
    logic [7:0] dummy;
    if (pop_pend && (rx_q.size() > 0)) dummy = rx_q.pop_front();
    pop_pend = rd_uart;
    rx_empty = (rx_q.size() == 0);
    r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Output monitor: echo and commit scoreboards
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_uart) rd_cnt++;
      if (wr_uart) begin
        wr_cnt++;
        check("rd_during_wr", rd_uart, 1'b0);
        check("echo_expected", (echo_q.size() > 0), 1'b1);
        if (echo_q.size() > 0) check("echo_byte", w_data, echo_q.pop_front());
      end
      if (hex_valid) begin
        hv_cnt++;
        check("hex_expected", (hex_q.size() > 0), 1'b1);
        if (hex_q.size() > 0) check("hex_value", hex_value, hex_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, hv0, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex_value", hex_value, 8'h00);
    check("rst_hex_valid", hex_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rd_uart", rd_uart, 1'b0);
    check("rst_wr_uart", wr_uart, 1'b0);
    check("rst_w_data", w_data, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // "3c" CR
    rd0 = rd_cnt; wr0 = wr_cnt; hv0 = hv_cnt;
    send(8'h33); send(8'h63); send(CR);
    hex_q.push_back(8'h3C);
    settle("t1");
    check("t1_value", hex_value, 8'h3C);
    check("t1_pulses", hv_cnt - hv0, 1);
    check("t1_err", err, 1'b0);
    check("t1_rd_pulses", rd_cnt - rd0, 3);
    check("t1_wr_pulses", wr_cnt - wr0, (ECHO_ON != 0) ? 4 : 0);

    // "12A" CR keeps the last two digits
    send(8'h31); send(8'h32); send(8'h41); send(CR);
    hex_q.push_back(8'h2A);
    settle("t2");
    check("t2_value", hex_value, 8'h2A);

    // "5G" CR flags an error and commits nothing
    hv0 = hv_cnt;
    send(8'h35); send(8'h47); send(CR);
    settle("t3");
    check("t3_err", err, 1'b1);
    check("t3_pulses", hv_cnt - hv0, 0);
    check("t3_value_held", hex_value, 8'h2A);

    // "FF" CR commits and clears the error
    send(8'h46); send(8'h66); send(CR);
    hex_q.push_back(8'hFF);
    settle("t4");
    check("t4_value", hex_value, 8'hFF);
    check("t4_err", err, 1'b0);

    // "7" BS "9" CR, then a lone CR
    send(8'h37); send(BS); send(8'h39); send(CR);
    hex_q.push_back(8'h09);
    settle("t5");
    check("t5_value", hex_value, 8'h09);
    hv0 = hv_cnt;
    send(CR);
    settle("t6");
    check("t6_lone_cr_pulses", hv_cnt - hv0, 0);
    check("t6_value_held", hex_value, 8'h09);

    // TX backpressure during the echo of "A"
    tx_full = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(8'h41); send(8'h42);
    repeat (20) @(posedge clk);
    #1;
    check("t7_rd_stalled", rd_cnt - rd0, (ECHO_ON != 0) ? 1 : 2);
    check("t7_wr_stalled", wr_cnt - wr0, 0);
    check("t7_w_data_hold", w_data, (ECHO_ON != 0) ? 8'h41 : 8'h00);
    tx_full = 1'b0;
    settle("t7");
    check("t7_rd_after", rd_cnt - rd0, 2);
    check("t7_wr_after", wr_cnt - wr0, (ECHO_ON != 0) ? 2 : 0);
    send(CR);
    hex_q.push_back(8'hAB);
    settle("t7b");
    check("t7_value", hex_value, 8'hAB);

    // Raise err, then reset while "4" is being decoded
    send(8'h5A);
    settle("t8a");
    check("t8_err_set", err, 1'b1);
    rx_q.push_back(8'h34);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_uart && (n < 50));
    check("t8_pop_seen", rd_uart, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t8_rst_hex_value", hex_value, 8'h00);
    check("t8_rst_hex_valid", hex_valid, 1'b0);
    check("t8_rst_err", err, 1'b0);
    check("t8_rst_rd_uart", rd_uart, 1'b0);
    check("t8_rst_wr_uart", wr_uart, 1'b0);
    check("t8_rst_w_data", w_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(8'h38); send(CR);
    hex_q.push_back(8'h08);
    settle("t9");
    check("t9_value", hex_value, 8'h08);
    check("t9_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
